// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl
//   Score controller for a two-player Pong game. Keeps two-digit BCD scores
//   and sequences a 4-digit seven-segment driver. After a goal, the scorer's
//   digit pair blinks for a fixed number of half-periods. When a player
//   reaches WIN_SCORE, the game holds in a game-over state and the winner's
//   pair blinks until new_game.
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   point_p1  single-cycle pulse: player 1 scored
//   point_p2  single-cycle pulse: player 2 scored
//   new_game  single-cycle pulse: clear scores and restart
//   disp3     P1 tens digit code (leftmost); 4'hF renders as a dash
//   disp2     P1 ones digit code
//   disp1     P2 tens digit code
//   disp0     P2 ones digit code (rightmost)
//   busy      high while a goal or game-over sequence runs
//   winner    0 = none, 1 = P1, 2 = P2
//
// The outputs are registered copies of a decode of the next-state values.
// They therefore equal a decode of the current state registers, and an event
// sampled at a clock edge is visible right after that edge.
module pong_score_ctrl #(
  parameter int WIN_SCORE     = 7,
  parameter int BLINK_HALF    = 25_000_000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       new_game,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic       busy,
  output logic [1:0] winner
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TOG_LAST   = TW'(BLINK_TOGGLES - 1);
  // Winning score as BCD so the compare needs no binary conversion.
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_GOAL = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [3:0]     p1_tens_r, p1_ones_r, p2_tens_r, p2_ones_r;
  logic [3:0]     p1_tens_s, p1_ones_s, p2_tens_s, p2_ones_s;
  logic           scorer_r, scorer_s;
  logic [BW-1:0]  blink_cnt_r, blink_cnt_s;
  logic           phase_r, phase_s;
  logic [TW-1:0]  tog_cnt_r, tog_cnt_s;
  logic [1:0]     winner_r, winner_s;
  logic [7:0]     p1_inc_s, p2_inc_s, sel_inc_s;
  logic [15:0]    disp_s;

  // Two-digit BCD increment: {tens, ones} -> {tens, ones} + 1.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

  // Digit codes for a given state: a blanked pair shows 4'hF on both digits
  // during the dark half (phase 0) of the blink.
  function automatic logic [15:0] disp_decode(
    input state_t     st,
    input logic [3:0] a_tens,
    input logic [3:0] a_ones,
    input logic [3:0] b_tens,
    input logic [3:0] b_ones,
    input logic       sc,
    input logic [1:0] win,
    input logic       ph
  );
    logic blank_a;
    logic blank_b;
    blank_a = 1'b0;
    blank_b = 1'b0;
    if (!ph) begin
      case (st)
        ST_GOAL: begin
          blank_a = (sc == 1'b0);
          blank_b = (sc == 1'b1);
        end
        ST_OVER: begin
          blank_a = (win == 2'd1);
          blank_b = (win == 2'd2);
        end
        default: begin
          blank_a = 1'b0;
          blank_b = 1'b0;
        end
      endcase
    end else begin
      blank_a = 1'b0;
      blank_b = 1'b0;
    end
    return {blank_a ? 4'hF : a_tens, blank_a ? 4'hF : a_ones,
            blank_b ? 4'hF : b_tens, blank_b ? 4'hF : b_ones};
  endfunction

  assign p1_inc_s  = bcd_inc(p1_tens_r, p1_ones_r);
  assign p2_inc_s  = bcd_inc(p2_tens_r, p2_ones_r);
  assign sel_inc_s = point_p2 ? p2_inc_s : p1_inc_s;

  // Next-state logic for the game FSM, scores and blink counters.
  always_comb begin
    state_s     = state_r;
    p1_tens_s   = p1_tens_r;
    p1_ones_s   = p1_ones_r;
    p2_tens_s   = p2_tens_r;
    p2_ones_s   = p2_ones_r;
    scorer_s    = scorer_r;
    blink_cnt_s = blink_cnt_r;
    phase_s     = phase_r;
    tog_cnt_s   = tog_cnt_r;
    winner_s    = winner_r;

    if (new_game) begin
      // Restart wins over any point pulse in the same cycle.
      state_s     = ST_PLAY;
      p1_tens_s   = 4'd0;
      p1_ones_s   = 4'd0;
      p2_tens_s   = 4'd0;
      p2_ones_s   = 4'd0;
      blink_cnt_s = {BW{1'b0}};
      phase_s     = 1'b0;
      tog_cnt_s   = {TW{1'b0}};
      winner_s    = 2'd0;
    end else begin
      case (state_r)
        ST_PLAY: begin
          // Simultaneous points cancel each other.
          if (point_p1 ^ point_p2) begin
            scorer_s    = point_p2;
            blink_cnt_s = {BW{1'b0}};
            phase_s     = 1'b0;
            tog_cnt_s   = {TW{1'b0}};
            if (point_p2) begin
              p2_tens_s = sel_inc_s[7:4];
              p2_ones_s = sel_inc_s[3:0];
            end else begin
              p1_tens_s = sel_inc_s[7:4];
              p1_ones_s = sel_inc_s[3:0];
            end
            if (sel_inc_s == WIN_BCD) begin
              state_s  = ST_OVER;
              winner_s = point_p2 ? 2'd2 : 2'd1;
            end else begin
              state_s = ST_GOAL;
            end
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_GOAL: begin
          if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_s = {BW{1'b0}};
            if (tog_cnt_r == TOG_LAST) begin
              state_s   = ST_PLAY;
              phase_s   = 1'b0;
              tog_cnt_s = {TW{1'b0}};
            end else begin
              phase_s   = ~phase_r;
              tog_cnt_s = tog_cnt_r + TW'(1);
            end
          end else begin
            blink_cnt_s = blink_cnt_r + BW'(1);
          end
        end
        ST_OVER: begin
          // Blink forever; scores stay frozen until new_game.
          if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_s = {BW{1'b0}};
            phase_s     = ~phase_r;
          end else begin
            blink_cnt_s = blink_cnt_r + BW'(1);
          end
        end
        default: begin
          state_s = ST_PLAY;
        end
      endcase
    end
  end

  assign disp_s = disp_decode(state_s, p1_tens_s, p1_ones_s, p2_tens_s, p2_ones_s,
                              scorer_s, winner_s, phase_s);

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_PLAY;
      p1_tens_r   <= 4'd0;
      p1_ones_r   <= 4'd0;
      p2_tens_r   <= 4'd0;
      p2_ones_r   <= 4'd0;
      scorer_r    <= 1'b0;
      blink_cnt_r <= {BW{1'b0}};
      phase_r     <= 1'b0;
      tog_cnt_r   <= {TW{1'b0}};
      winner_r    <= 2'd0;
    end else begin
      state_r     <= state_s;
      p1_tens_r   <= p1_tens_s;
      p1_ones_r   <= p1_ones_s;
      p2_tens_r   <= p2_tens_s;
      p2_ones_r   <= p2_ones_s;
      scorer_r    <= scorer_s;
      blink_cnt_r <= blink_cnt_s;
      phase_r     <= phase_s;
      tog_cnt_r   <= tog_cnt_s;
      winner_r    <= winner_s;
    end
  end

  // Output registers, loaded with the decode of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp3  <= 4'd0;
      disp2  <= 4'd0;
      disp1  <= 4'd0;
      disp0  <= 4'd0;
      busy   <= 1'b0;
      winner <= 2'd0;
    end else begin
      disp3  <= disp_s[15:12];
      disp2  <= disp_s[11:8];
      disp1  <= disp_s[7:4];
      disp0  <= disp_s[3:0];
      busy   <= (state_s != ST_PLAY);
      winner <= winner_s;
    end
  end

endmodule
